// File: rtl/pipe_method_demux.sv
// pipe_method_demux
// Assembles 32-bit beat-stream messages (one header beat plus 0..MAX_ARGS
// argument beats) into a DEPTH-entry FIFO and dispatches the head message to
// one of NUM_METHODS method ports using ENA/RDY handshakes.
// Optional feature: define PIPE_DEMUX_ERRCNT_EN to add the saturating
// 16-bit dropped-message counter on the 'errors' port.
module pipe_method_demux #(
  parameter int NUM_METHODS = 4,
  parameter int MAX_ARGS    = 3,
  parameter int DEPTH       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     pipe_enq__ENA,
  input  logic [31:0]              pipe_enq_v,
  output logic                     pipe_enq__RDY,
  output logic [NUM_METHODS-1:0]   method__ENA,
  output logic [MAX_ARGS*32-1:0]   method_args,
  output logic [7:0]               method_len,
  input  logic [NUM_METHODS-1:0]   method__RDY
`ifdef PIPE_DEMUX_ERRCNT_EN
  ,
  output logic [15:0]              errors
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int IDW  = (NUM_METHODS > 1) ? $clog2(NUM_METHODS) : 1;
  localparam int ARGW = MAX_ARGS * 32;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_ARG  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      beat_idx;
  logic [7:0]      beat_len;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW-1:0]   wa;
  logic [AW-1:0]   ra;

  logic [IDW-1:0]  mem_id   [DEPTH];
  logic [7:0]      mem_len  [DEPTH];
  logic [ARGW-1:0] mem_args [DEPTH];

  logic [ARGW-1:0] held_args;
  logic [7:0]      held_len;

  logic [15:0]     hdr_id;
  logic [7:0]      hdr_len;
  logic            hdr_valid;
  logic            accept;
  logic            last_beat;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [IDW-1:0]  head_id;

  assign hdr_id     = pipe_enq_v[15:0];
  assign hdr_len    = pipe_enq_v[23:16];
  assign hdr_valid  = (hdr_id < 16'(NUM_METHODS)) && (hdr_len <= 8'(MAX_ARGS));

  assign wa         = wr_ptr[AW-1:0];
  assign ra         = rd_ptr[AW-1:0];
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wa == ra);

  // Headers wait for a free slot; once a message is under way its slot is
  // already reserved, so argument and drop beats are always taken.
  assign pipe_enq__RDY = (state == S_HDR) ? !fifo_full : 1'b1;
  assign accept        = pipe_enq__ENA & pipe_enq__RDY;
  assign last_beat     = (beat_idx == beat_len - 8'd1);
  assign push          = accept &&
                         (((state == S_HDR) && hdr_valid && (hdr_len == 8'd0)) ||
                          ((state == S_ARG) && last_beat));

  assign head_id       = mem_id[ra];
  assign pop           = !fifo_empty && method__RDY[head_id];

  // Strict head-of-line dispatch: only the head's method may fire.
  always_comb begin
    method__ENA = '0;
    if (pop) method__ENA[head_id] = 1'b1;
  end

  // Head fields come straight from the FIFO; while empty the last head is held.
  assign method_args = fifo_empty ? held_args : mem_args[ra];
  assign method_len  = fifo_empty ? held_len  : mem_len[ra];

  // Assembler FSM, write pointer and (optionally) the drop counter.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_HDR;
      beat_idx <= 8'd0;
      beat_len <= 8'd0;
      wr_ptr   <= '0;
`ifdef PIPE_DEMUX_ERRCNT_EN
      errors   <= 16'd0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (accept) begin
        case (state)
          S_HDR: begin
            beat_idx <= 8'd0;
            beat_len <= hdr_len;
            if (hdr_len != 8'd0) state <= hdr_valid ? S_ARG : S_DROP;
`ifdef PIPE_DEMUX_ERRCNT_EN
            if (!hdr_valid && (errors != 16'hFFFF)) errors <= errors + 16'd1;
`endif
          end
          S_ARG, S_DROP: begin
            beat_idx <= beat_idx + 8'd1;
            if (last_beat) state <= S_HDR;
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

  // Message storage: the header clears the reserved slot, then each argument
  // beat lands in its word, so unused words are always zero.
  // NOTE: the storage array has no reset; every slot is fully rewritten by its
  // header before it can become visible, and the empty-FIFO outputs come from
  // the reset-cleared hold registers instead.
  always_ff @(posedge CLK) begin
    if (accept && (state == S_HDR) && hdr_valid) begin
      mem_id[wa]   <= hdr_id[IDW-1:0];
      mem_len[wa]  <= hdr_len;
      mem_args[wa] <= '0;
    end
    if (accept && (state == S_ARG)) begin
      for (int k = 0; k < MAX_ARGS; k++) begin
        if (beat_idx == 8'(k)) mem_args[wa][32*k +: 32] <= pipe_enq_v;
      end
    end
  end

  // Read pointer and hold copy of the head for the empty-FIFO output values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr    <= '0;
      held_args <= '0;
      held_len  <= 8'd0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (!fifo_empty) begin
        held_args <= mem_args[ra];
        held_len  <= mem_len[ra];
      end
    end
  end

endmodule

// File: tb/tb_pipe_method_demux.sv
// Testbench for pipe_method_demux: directed scenarios plus a randomized run
// checked against a message-level queue model.
module tb_pipe_method_demux;

  localparam int NM    = 4;
  localparam int MA    = 3;
  localparam int DEPTH = 4;
  localparam int NRAND = 60;

  typedef struct {
    int              id;
    int              len;
    logic [MA*32-1:0] args;
    int              cyc;
  } msg_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            enq_ena;
  logic [31:0]     enq_v;
  logic            enq_rdy;
  logic [NM-1:0]   m_ena;
  logic [MA*32-1:0] m_args;
  logic [7:0]      m_len;
  logic [NM-1:0]   m_rdy;
`ifdef PIPE_DEMUX_ERRCNT_EN
  logic [15:0]     errors;
`endif

  int   tests;
  int   fails;
  int   err_model;
  int   bad_hot;
  int   bad_rdy;
  bit   obs_done;
  msg_t got[$];
  msg_t exp_q[$];

  always #5 clk = ~clk;

  pipe_method_demux #(.NUM_METHODS(NM), .MAX_ARGS(MA), .DEPTH(DEPTH)) dut (
    .CLK           (clk),
    .RST           (rst),
    .pipe_enq__ENA (enq_ena),
    .pipe_enq_v    (enq_v),
    .pipe_enq__RDY (enq_rdy),
    .method__ENA   (m_ena),
    .method_args   (m_args),
    .method_len    (m_len),
    .method__RDY   (m_rdy)
`ifdef PIPE_DEMUX_ERRCNT_EN
    ,
    .errors        (errors)
`endif
  );

  // Called at posedge+1; waits for RDY before asserting ENA, holds it one edge.
  task automatic send_beat(input logic [31:0] v);
    int t;
    t = 0;
    while (!enq_rdy && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      tests++; fails++;
      $display("FAIL rdy_timeout: pipe RDY still %0b after %0d cycles, required 1", enq_rdy, t);
    end
    enq_ena = 1'b1;
    enq_v   = v;
    @(posedge clk); #1;
    enq_ena = 1'b0;
  endtask

  task automatic send_msg(input int id, input int n, input logic [MA*32-1:0] a);
    logic [7:0]  nb;
    logic [15:0] ib;
    nb = n[7:0];
    ib = id[15:0];
    send_beat({8'($urandom), nb, ib});
    for (int k = 0; k < n; k++) begin
      if (k < MA) send_beat(a[32*k +: 32]);
      else        send_beat($urandom);
    end
  endtask

  // Expected message as the reference sees it: only the first n words survive.
  function automatic msg_t model_msg(input int id, input int n, input logic [MA*32-1:0] a);
    msg_t m;
    m.id   = id;
    m.len  = n;
    m.args = '0;
    for (int k = 0; k < MA; k++) if (k < n) m.args[32*k +: 32] = a[32*k +: 32];
    m.cyc  = 0;
    return m;
  endfunction

  // Records every fire seen on the method ports (no judging here).
  task automatic observe(input int ncyc, input int stop_after);
    got.delete();
    bad_hot = 0;
    bad_rdy = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (m_ena != '0) begin
        msg_t m;
        if ($countones(m_ena) != 1) bad_hot++;
        m.id = 0;
        for (int j = 0; j < NM; j++) if (m_ena[j]) m.id = j;
        if (!m_rdy[m.id]) bad_rdy++;
        m.len  = int'(m_len);
        m.args = m_args;
        m.cyc  = i;
        got.push_back(m);
        if (got.size() >= stop_after) break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if (enq_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b expected 1", enq_rdy); end
    tests++; if (m_ena !== 4'b0000) begin fails++; $display("FAIL reset_ena: got %b expected 0000", m_ena); end
    tests++; if (m_args !== '0) begin fails++; $display("FAIL reset_args: got %h expected 0", m_args); end
    tests++; if (m_len !== 8'd0) begin fails++; $display("FAIL reset_len: got %0d expected 0", m_len); end
`ifdef PIPE_DEMUX_ERRCNT_EN
    tests++; if (errors !== 16'd0) begin fails++; $display("FAIL reset_errors: got %0d expected 0", errors); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    send_beat(32'h0002_0001);
    send_beat(32'hAAAA0001);
    send_beat(32'hBBBB0002);
    @(negedge clk);
    tests++; if (m_ena !== 4'b0010) begin fails++; $display("FAIL single_ena: got %b expected 0010", m_ena); end
    tests++; if (m_args !== {32'h0, 32'hBBBB0002, 32'hAAAA0001}) begin
      fails++; $display("FAIL single_args: got %h expected %h", m_args, {32'h0, 32'hBBBB0002, 32'hAAAA0001});
    end
    tests++; if (m_len !== 8'd2) begin fails++; $display("FAIL single_len: got %0d expected 2", m_len); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_arg;
    send_beat(32'h0000_0003);
    @(negedge clk);
    tests++; if (m_ena !== 4'b1000) begin fails++; $display("FAIL zero_ena: got %b expected 1000", m_ena); end
    tests++; if (m_args !== '0) begin fails++; $display("FAIL zero_args: got %h expected 0", m_args); end
    tests++; if (m_len !== 8'd0) begin fails++; $display("FAIL zero_len: got %0d expected 0", m_len); end
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    msg_t e[5];
    m_rdy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      send_msg(k, 1, {64'h0, 32'h1000 + 32'(k)});
      e[k] = model_msg(k, 1, {64'h0, 32'h1000 + 32'(k)});
      if (k == DEPTH - 2) begin
        tests++; if (enq_rdy !== 1'b1) begin fails++; $display("FAIL full_not_yet: rdy got %b expected 1", enq_rdy); end
      end
    end
    e[4] = model_msg(2, 1, {64'h0, 32'h5555});
    @(negedge clk);
    tests++; if (enq_rdy !== 1'b0) begin fails++; $display("FAIL full_rdy: got %b expected 0", enq_rdy); end
    tests++; if (m_ena !== 4'b0000) begin fails++; $display("FAIL full_stalled_ena: got %b expected 0000", m_ena); end
    @(posedge clk); #1;
    fork
      send_msg(2, 1, {64'h0, 32'h5555});
      begin @(posedge clk); #1; m_rdy = '1; end
      observe(60, 5);
    join
    tests++; if (got.size() != 5) begin fails++; $display("FAIL full_count: got %0d expected 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      tests++;
      if (got[k].id != e[k].id || got[k].len != e[k].len || got[k].args !== e[k].args) begin
        fails++;
        $display("FAIL full_order[%0d]: got id%0d len%0d %h expected id%0d len%0d %h",
                 k, got[k].id, got[k].len, got[k].args, e[k].id, e[k].len, e[k].args);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_drop;
    send_msg(7, 2, {32'h0, 32'hDEAD0002, 32'hDEAD0001});
    err_model++;
    send_msg(0, 1, {64'h0, 32'hC0DE});
    observe(8, 100);
    tests++; if (got.size() != 1) begin fails++; $display("FAIL drop_count: got %0d fires expected 1", got.size()); end
    if (got.size() >= 1) begin
      tests++;
      if (got[0].id != 0 || got[0].len != 1 || got[0].args !== {64'h0, 32'hC0DE}) begin
        fails++; $display("FAIL drop_next: got id%0d len%0d %h expected id0 len1 %h",
                          got[0].id, got[0].len, got[0].args, {64'h0, 32'hC0DE});
      end
    end
`ifdef PIPE_DEMUX_ERRCNT_EN
    tests++; if (errors !== 16'(err_model)) begin fails++; $display("FAIL drop_errors: got %0d expected %0d", errors, err_model); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset;
    send_beat(32'h0003_0002);
    send_beat(32'hFEED0001);
    rst = 1'b1;
    err_model = 0;
    #1;
    tests++; if (enq_rdy !== 1'b1) begin fails++; $display("FAIL midrst_rdy: got %b expected 1", enq_rdy); end
    tests++; if (m_ena !== 4'b0000) begin fails++; $display("FAIL midrst_ena: got %b expected 0000", m_ena); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_msg(1, 1, {64'h0, 32'h1234});
    @(negedge clk);
    tests++; if (m_ena !== 4'b0010) begin fails++; $display("FAIL midrst_fire: got %b expected 0010", m_ena); end
    tests++; if (m_args !== {64'h0, 32'h1234}) begin
      fails++; $display("FAIL midrst_args: got %h expected %h", m_args, {64'h0, 32'h1234});
    end
    tests++; if (m_len !== 8'd1) begin fails++; $display("FAIL midrst_len: got %0d expected 1", m_len); end
`ifdef PIPE_DEMUX_ERRCNT_EN
    tests++; if (errors !== 16'd0) begin fails++; $display("FAIL midrst_errors: got %0d expected 0", errors); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_hol;
    m_rdy = 4'b1011;
    send_msg(2, 0, '0);
    send_msg(0, 1, {64'h0, 32'h77});
    observe(6, 100);
    tests++; if (got.size() != 0) begin fails++; $display("FAIL hol_blocked: got %0d fires expected 0", got.size()); end
    @(posedge clk); #1;
    m_rdy = '1;
    observe(6, 2);
    tests++; if (got.size() != 2) begin fails++; $display("FAIL hol_count: got %0d expected 2", got.size()); end
    if (got.size() == 2) begin
      tests++; if (got[0].id != 2 || got[0].cyc != 0) begin
        fails++; $display("FAIL hol_first: got id%0d at cycle %0d expected id2 at cycle 0", got[0].id, got[0].cyc);
      end
      tests++; if (got[1].id != 0 || got[1].cyc != 1 || got[1].args !== {64'h0, 32'h77}) begin
        fails++; $display("FAIL hol_second: got id%0d at cycle %0d args %h expected id0 at cycle 1 args %h",
                          got[1].id, got[1].cyc, got[1].args, {64'h0, 32'h77});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int               hid[NRAND];
    int               hn[NRAND];
    logic [MA*32-1:0] ha[NRAND];
    int               nexp;
    exp_q.delete();
    for (int i = 0; i < NRAND; i++) begin
      hid[i] = $urandom_range(0, 5);
      hn[i]  = $urandom_range(0, 4);
      ha[i]  = {$urandom, $urandom, $urandom};
      if (hid[i] < NM && hn[i] <= MA) exp_q.push_back(model_msg(hid[i], hn[i], ha[i]));
      else err_model++;
    end
    nexp = exp_q.size();
    obs_done = 1'b0;
    fork
      begin
        for (int i = 0; i < NRAND; i++) send_msg(hid[i], hn[i], ha[i]);
      end
      begin
        while (!obs_done) begin
          @(posedge clk); #1;
          if (!obs_done) m_rdy = NM'($urandom);
        end
      end
      begin
        observe(4000, nexp);
        obs_done = 1'b1;
      end
    join
    m_rdy = '1;
    tests++; if (got.size() != nexp) begin fails++; $display("FAIL rand_count: got %0d expected %0d", got.size(), nexp); end
    tests++; if (bad_hot != 0) begin fails++; $display("FAIL rand_onehot: got %0d non-one-hot fires expected 0", bad_hot); end
    tests++; if (bad_rdy != 0) begin fails++; $display("FAIL rand_rdy: got %0d fires without RDY expected 0", bad_rdy); end
    for (int k = 0; k < nexp && k < got.size(); k++) begin
      tests++;
      if (got[k].id != exp_q[k].id || got[k].len != exp_q[k].len || got[k].args !== exp_q[k].args) begin
        fails++;
        $display("FAIL rand_msg[%0d]: got id%0d len%0d %h expected id%0d len%0d %h",
                 k, got[k].id, got[k].len, got[k].args, exp_q[k].id, exp_q[k].len, exp_q[k].args);
      end
    end
`ifdef PIPE_DEMUX_ERRCNT_EN
    tests++; if (errors !== 16'(err_model)) begin fails++; $display("FAIL rand_errors: got %0d expected %0d", errors, err_model); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    err_model = 0;
    rst       = 1'b1;
    enq_ena   = 1'b0;
    enq_v     = '0;
    m_rdy     = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_single;
    test_zero_arg;
    test_full;
    test_drop;
    test_mid_reset;
    test_hol;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
